// File: rtl/reg_pkg.sv
// reg_pkg: register select encoding and the signed count type shared by the register file
package reg_pkg;
   localparam int COUNT_W = 8;
   typedef enum logic [3:0] {
      REG_R0, REG_R1, REG_R2, REG_R3, REG_R4, REG_R5, REG_R6, REG_R7,
      REG_R8, REG_R9, REG_R10, REG_R11, REG_R12,
      REG_PC = 4'd13, REG_SP = 4'd14, REG_FP = 4'd15
   } reg_e;
   typedef logic signed [COUNT_W-1:0] count_t;
endpackage

// File: rtl/reg_cell.sv
// reg_cell: one register with sync reset, load, and a wide signed adjust truncated on update
module reg_cell #(
   parameter int WIDTH = 32,
   parameter int ADJ_WIDTH = 34
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld,
   input  logic [WIDTH-1:0]     d,
   input  logic [ADJ_WIDTH-1:0] adj,
   output logic [WIDTH-1:0]     q
);
   // load beats the adjust; the adjust is added at full width and wraps silently
   always_ff @(posedge clk)
      q <= rst ? '0 : ld ? d : WIDTH'(ADJ_WIDTH'(q) + adj);
endmodule

// File: rtl/multi_port_reg_file.sv
// multi_port_reg_file: NUM_REGS x WIDTH register file with READ_PORTS read/count ports and one write port
module multi_port_reg_file
   import reg_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEL_WIDTH = 4,
   parameter int READ_PORTS = 2,
   parameter int COUNT_WIDTH = 8,
   parameter int BYPASS = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [READ_PORTS-1:0]             oe,
   input  logic [READ_PORTS*SEL_WIDTH-1:0]   sel,
   input  logic [READ_PORTS*COUNT_WIDTH-1:0] count,
   output logic [READ_PORTS*WIDTH-1:0]       out,
   input  logic                              ld,
   input  logic [SEL_WIDTH-1:0]              wr_sel,
   input  logic [WIDTH-1:0]                  in,
   output logic [(2**SEL_WIDTH)*WIDTH-1:0]   value
);
   localparam int NUM_REGS = 2**SEL_WIDTH;
   localparam int SUM_WIDTH = WIDTH + $clog2(READ_PORTS) + 1;
   logic [WIDTH-1:0]     q   [NUM_REGS];
   logic [SUM_WIDTH-1:0] adj [NUM_REGS];
   // per register, sum the sign-extended counts of every port selecting it
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         adj[r] = '0;
         for (int k = 0; k < READ_PORTS; k++)
            if (sel[k*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(r))
               adj[r] = adj[r] + SUM_WIDTH'($signed(count[k*COUNT_WIDTH +: COUNT_WIDTH]));
      end
   end
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
      reg_cell #(.WIDTH(WIDTH), .ADJ_WIDTH(SUM_WIDTH)) u_cell (
         .clk(clk),
         .rst(rst),
         .ld(ld && wr_sel == SEL_WIDTH'(g)),
         .d(in),
         .adj(adj[g]),
         .q(q[g])
      );
      assign value[g*WIDTH +: WIDTH] = q[g];
   end
   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      logic [SEL_WIDTH-1:0] s;
      assign s = sel[p*SEL_WIDTH +: SEL_WIDTH];
      assign out[p*WIDTH +: WIDTH] = oe[p] ? ((BYPASS != 0 && ld && wr_sel == s) ? in : q[s]) : 'z;
   end
endmodule

// File: doc/multi_port_reg_file.md
Name: multi_port_reg_file

Overview:
Parametrised successor to the CPU's two-port public register file. It provides NUM_REGS registers of WIDTH bits, with READ_PORTS independent read ports and one write port. Each read port carries a post-read signed count adjust, used for PC increment and SP push/pop. The block sits between the register read buses (feeding the operand filters/ALU) and the result bus (write-back). It adds an optional write-to-read bypass and defined merge rules for simultaneous updates.

Parameters:
WIDTH, 32, register and bus width in bits
SEL_WIDTH, 4, select width; NUM_REGS = 2**SEL_WIDTH
READ_PORTS, 2, number of read/count ports (>=1)
COUNT_WIDTH, 8, width of each signed count input
BYPASS, 0, 1 = read of a register being written this cycle returns wr_data; 0 = returns the old value

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
oe  input  READ_PORTS  per-port output enable
sel  input  READ_PORTS*SEL_WIDTH  per-port register select, port p at [p*SEL_WIDTH +: SEL_WIDTH]
count  input  READ_PORTS*COUNT_WIDTH  per-port signed post-adjust, port p at [p*COUNT_WIDTH +: COUNT_WIDTH]
out  output(tri)  READ_PORTS*WIDTH  per-port read data, port p at [p*WIDTH +: WIDTH]
ld  input  1  write enable
wr_sel  input  SEL_WIDTH  write select
in  input  WIDTH  write data (result bus)
value  output  NUM_REGS*WIDTH  flat debug/observation view of all registers

Behaviour:
- Reset: on a rising clk edge with rst=1, all registers become 0. ld and count are ignored that cycle. value reads 0 from the next cycle.
- Read: combinational; no clock latency.
  - oe[p]=1: out port p = reg[sel[p]], or in when BYPASS=1 && ld && wr_sel==sel[p].
  - oe[p]=0: out port p = 'z.
  - The read is unaffected by count in the same cycle; count is a post-adjust.
- Count: count[p] is sign-extended to WIDTH. It applies at the clock edge to reg[sel[p]] whether or not oe[p] is set, so a port can inc/dec without driving its bus.
  - count=0 means no change.
- Merge rules at each edge, per register r:
  - If ld && wr_sel==r, the next value is in; all counts targeting r are discarded (write wins).
  - Otherwise the next value is reg[r] + the sum of sign-extended count[p] over every port p with sel[p]==r.
  - The sum is computed at WIDTH+$clog2(READ_PORTS)+1 bits, then truncated to WIDTH.
- Arithmetic: modulo 2**WIDTH; wrap is silent, no flags.
  - 32'hFFFF_FFFF + 1 -> 0.
  - 0 + (-1) -> 32'hFFFF_FFFF.
- Multiple ports may select the same register for reading simultaneously; each receives the same value.
- No special registers: PC/SP semantics belong to the controller. Register 0 is writable.
- Reset mid-operation: a pending write or count in the reset cycle is lost.

Decomposition:
- reg_pkg: the existing reg_e enum (the sel encoding), extended with named constants REG_PC=13, REG_SP=14, REG_FP=15, and a count_t typedef (signed [COUNT_WIDTH-1:0]).
- Sub-module reg_cell:
  - One WIDTH-bit register with synchronous reset, load, and a signed add input.
  - The top generates NUM_REGS instances.
  - The top builds, per register, the summed adjust and the load-hit decode.

Test Plan:
1. Reset then read: assert rst one cycle, then oe=2'b11, sel0=3, sel1=15 -> both outputs 0; with oe=0 both outputs are high-Z.
2. Write/read latency (BYPASS=0): ld=1, wr_sel=5, in=32'hDEAD_BEEF, with port0 reading reg 5 in the same cycle -> old value 0; next cycle -> 32'hDEAD_BEEF. Repeat with BYPASS=1 -> 32'hDEAD_BEEF in the same cycle.
3. Post-increment: reg13=100, port0 sel=13, count=+1, oe=1 -> reads 100 this cycle, 101 next cycle; count=-4 on reg14=0 -> 32'hFFFF_FFFC.
4. Count merge: port0 and port1 both select reg 2 (value 10), counts +3 and -1 -> next value 12; same cycle with ld to reg 2, in=7 -> 7.
5. Wrap and width: reg1=32'hFFFF_FFFF, count=+1 -> 0; count=8'h80 on reg1=0 -> 32'hFFFF_FF80.
6. Reset mid-operation: ld to reg 4 plus count to reg 4 together with rst=1 -> reg4=0 next cycle; run with READ_PORTS=3 and WIDTH=16 to check generalisation.
